sdram_init_checker: RTL and testbench
=====================================

# sdram_init_checker

Synthesizable command-bus receiver for the SDRAM initialization sequence. It sits on the same `{cs_n, ras_n, cas_n, we_n}` / bank / address bus that drives the SDRAM, in parallel with the device. It decodes every command, checks the power-up ordering and the tRP, tRFC and tMRD spacing, and captures the programmed mode register. It serves as an in-circuit/simulation monitor for the controller's init path and reports pass, or the first failure, through sticky flags.

## Interface
Parameters:
- `T_POWER`, 20000: minimum idle cycles after reset before the first command (200 µs at 100 MHz).
- `T_RP`, 2: minimum cycles from PRECHARGE to the next command.
- `T_RFC`, 7: minimum cycles from AUTO_REFRESH to the next command.
- `T_MRD`, 3: minimum cycles from LOAD_MODE to the next command.
- `AREF_MIN`, 2: minimum AUTO_REFRESH count before LOAD_MODE.

Ports:
- `clk` in 1: command-bus clock (100 MHz domain, unshifted).
- `rst_n` in 1: reset. Asynchronous, active-low.
- `cmd` in 4: `{cs_n, ras_n, cas_n, we_n}`.
- `bank_addr` in 2: bank address.
- `addr` in 13: address bus. A10 is the all-banks bit.
- `init_ok` out 1: sticky. Sequence completed with no error.
- `init_err` out 1: sticky. An error was detected.
- `err_code` out 3: first error detected, latched.
- `aref_cnt` out 4: AUTO_REFRESH commands seen in the sequence, saturating at 15.
- `mode_bl` out 3: captured `addr[2:0]`.
- `mode_bt` out 1: captured `addr[3]`.
- `mode_cl` out 3: captured `addr[6:4]`.
- `mode_wb` out 1: captured `addr[9]`.

## Operation
- Command decode:
  - NOP = 0111; `cs_n` = 1 is DESELECT; both are idle.
  - PRECHARGE = 0010, AUTO_REFRESH = 0001, LOAD_MODE = 0000.
  - Any other value with `cs_n` = 0 is a command of class OTHER.
- A 17-bit gap counter saturates at its maximum.
  - Reset sets it to 0. It then increments every idle cycle.
  - On a command cycle it is checked first, then cleared to 1.
- States: `WAIT_PWR` → `WAIT_PRE` → `WAIT_AREF` → `DONE`. Any state can go to `ERR`.
- In `WAIT_PWR`:
  - Command with gap < `T_POWER` → `ERR`, code 1.
  - PRECHARGE with A10 = 1 → `WAIT_PRE` exit: go to `WAIT_AREF`.
  - Any other command → code 2.
- In `WAIT_AREF`:
  - The first command must be AUTO_REFRESH, and the gap since PRECHARGE must be ≥ `T_RP`, else code 3.
  - AUTO_REFRESH: requires gap ≥ `T_RFC` since the previous AUTO_REFRESH (code 4); increments `aref_cnt`.
  - LOAD_MODE: requires gap ≥ `T_RFC` (code 4) and `aref_cnt` ≥ `AREF_MIN` (code 5).
  - PRECHARGE or OTHER → code 2.
- LOAD_MODE legality (code 7 otherwise):
  - `addr[6:4]` ∈ {2, 3}.
  - `addr[8:7]` = 00.
  - `addr[2:0]` ∈ {0, 1, 2, 3}, or `addr[2:0]` = 7 with `addr[3]` = 0.
- Legal LOAD_MODE: capture the `mode_*` fields, assert `init_ok`, go to `DONE`.
- In `DONE`:
  - The first command after LOAD_MODE requires gap ≥ `T_MRD`, else code 6. This clears `init_ok`.
  - After that, all commands are accepted unchecked.
- In `ERR`: the state is absorbing. `err_code` and `init_err` hold until reset. Later errors are ignored.
- When a single command violates several rules, the lowest code wins (for example, an early LOAD_MODE in `WAIT_PWR` reports 1).

## Timing
- All outputs are registered and update on the rising edge that samples the command. They are visible the cycle after the command is on the bus.
- Gap definition: a command sampled at edge t2 after a command at edge t1 has gap t2 − t1. For the power-up check, t1 is the first rising edge with `rst_n` high, counted as 0.
- Reset values: `init_ok` = 0, `init_err` = 0, `err_code` = 0, `aref_cnt` = 0, all `mode_*` = 0, state `WAIT_PWR`, gap = 0.
- Asserting `rst_n` mid-sequence clears everything immediately, with no clock needed. After release, `T_POWER` idle cycles are required again.
- A command on the exact boundary edge (gap = T) is legal. Gap = T − 1 is a violation.
- The gap counter saturates at 2^17 − 1 and never wraps.

## Test plan
- Nominal run, `T_POWER` = 100: bus idle 100 cycles → PRECHARGE(A10 = 1) → gap 2 → AREF → gap 7 → AREF → gap 7 → LOAD_MODE `addr` = 0x032 → gap 3 → NOP.
  - Required: `init_ok` = 1, `mode_cl` = 3, `mode_bl` = 2, `aref_cnt` = 2, `init_err` = 0.
- PRECHARGE at cycle 99 → `err_code` = 1, `init_err` = 1.
  - A correct sequence applied afterwards leaves the code at 1.
- tRP boundary:
  - AREF one cycle after PRECHARGE → code 3.
  - A separate run with a gap of exactly 2 → no error.
- Only one AREF before a legal LOAD_MODE → code 5, `init_ok` = 0.
- LOAD_MODE `addr` = 0x014 (CL = 1) → code 7. A NOP 2 cycles after a legal LOAD_MODE → `init_ok` stays 1; a command 2 cycles after a legal LOAD_MODE → code 6, `init_ok` = 0.
- `rst_n` pulsed low after the second AREF:
  - All outputs return to 0 immediately.
  - A full nominal sequence afterwards yields `init_ok` = 1.

Source files
------------

// File: rtl/sdram_init_checker.sv
// sdram_init_checker: passive monitor for the SDRAM power-up/init sequence.
// Decodes the command bus, checks ordering and tRP/tRFC/tMRD spacing, and captures the mode register.
//
// Ports:
//   clk, rst_n      : command-bus clock, async active-low reset
//   cmd             : {cs_n, ras_n, cas_n, we_n}
//   bank_addr, addr : bank and address bus (addr[10] = all-banks)
//   init_ok         : sticky, sequence completed cleanly
//   init_err        : sticky, an error was seen
//   err_code        : first error code, latched
//   aref_cnt        : AUTO_REFRESH count, saturating at 15
//   mode_bl/bt/cl/wb: captured mode-register fields
module sdram_init_checker #(
    parameter int unsigned T_POWER  = 20000,
    parameter int unsigned T_RP     = 2,
    parameter int unsigned T_RFC    = 7,
    parameter int unsigned T_MRD    = 3,
    parameter int unsigned AREF_MIN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cmd,
    input  logic [1:0]  bank_addr,
    input  logic [12:0] addr,
    output logic        init_ok,
    output logic        init_err,
    output logic [2:0]  err_code,
    output logic [3:0]  aref_cnt,
    output logic [2:0]  mode_bl,
    output logic        mode_bt,
    output logic [2:0]  mode_cl,
    output logic        mode_wb
);

    typedef enum logic [2:0] {
        WAIT_PWR,
        WAIT_PRE,
        WAIT_AREF,
        DONE,
        ERR
    } state_e;

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [3:0]  CMD_AREF = 4'b0001;
    localparam logic [3:0]  CMD_LMR  = 4'b0000;

    localparam logic [16:0] GAP_MAX = '1;
    localparam logic [16:0] GAP_PWR = 17'(T_POWER);
    localparam logic [16:0] GAP_RP  = 17'(T_RP);
    localparam logic [16:0] GAP_RFC = 17'(T_RFC);
    localparam logic [16:0] GAP_MRD = 17'(T_MRD);
    localparam logic [3:0]  CNT_MIN = 4'(AREF_MIN);

    state_e      state_q, state_d;
    logic [16:0] gap_q, gap_d;
    logic        init_ok_q, init_ok_d;
    logic        init_err_q, init_err_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [3:0]  aref_cnt_q, aref_cnt_d;
    logic [2:0]  mode_bl_q, mode_bl_d;
    logic        mode_bt_q, mode_bt_d;
    logic [2:0]  mode_cl_q, mode_cl_d;
    logic        mode_wb_q, mode_wb_d;
    logic        mrd_pend_q, mrd_pend_d;

    logic        is_cmd;
    logic        is_pre;
    logic        is_aref;
    logic        is_lmr;
    logic        is_oth;
    logic        mode_legal;
    logic [16:0] gap_inc;
    logic [2:0]  code;
    logic        unused_bits;

    // Bank and upper address bits carry no meaning for the init checks.
    assign unused_bits = ^{bank_addr, addr[12:11]};

    assign is_cmd  = !cmd[3] && (cmd != CMD_NOP);
    assign is_pre  = is_cmd && (cmd == CMD_PRE);
    assign is_aref = is_cmd && (cmd == CMD_AREF);
    assign is_lmr  = is_cmd && (cmd == CMD_LMR);
    assign is_oth  = is_cmd && !is_pre && !is_aref && !is_lmr;

    // CL 2/3 only, no reserved op-mode bits, burst 1/2/4/8 or full page (sequential).
    assign mode_legal = ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3))
                     && (addr[8:7] == 2'b00)
                     && (!addr[2] || ((addr[2:0] == 3'd7) && !addr[3]));

    assign gap_inc = (gap_q == GAP_MAX) ? gap_q : gap_q + 17'd1;

    always_comb begin
        state_d    = state_q;
        gap_d      = is_cmd ? 17'd1 : gap_inc;
        init_ok_d  = init_ok_q;
        init_err_d = init_err_q;
        err_code_d = err_code_q;
        aref_cnt_d = aref_cnt_q;
        mode_bl_d  = mode_bl_q;
        mode_bt_d  = mode_bt_q;
        mode_cl_d  = mode_cl_q;
        mode_wb_d  = mode_wb_q;
        mrd_pend_d = mrd_pend_q;
        code       = 3'd0;

        unique case (state_q)
            WAIT_PWR, WAIT_PRE: begin
                if (is_cmd) begin
                    if (gap_q < GAP_PWR) begin
                        code = 3'd1;
                    end else if (is_pre && addr[10]) begin
                        state_d = WAIT_AREF;
                    end else begin
                        code = 3'd2;
                    end
                end else if (state_q == WAIT_PWR && gap_inc >= GAP_PWR) begin
                    // The next edge is already far enough from reset.
                    state_d = WAIT_PRE;
                end
            end
            WAIT_AREF: begin
                if (is_cmd) begin
                    if (is_pre || is_oth) begin
                        code = 3'd2;
                    end else if (aref_cnt_q == 4'd0
                                 && (!is_aref || gap_q < GAP_RP)) begin
                        code = 3'd3;
                    end else if (aref_cnt_q != 4'd0 && gap_q < GAP_RFC) begin
                        code = 3'd4;
                    end else if (is_aref) begin
                        if (aref_cnt_q != 4'hF) begin
                            aref_cnt_d = aref_cnt_q + 4'd1;
                        end
                    end else if (aref_cnt_q < CNT_MIN) begin
                        code = 3'd5;
                    end else if (!mode_legal) begin
                        code = 3'd7;
                    end else begin
                        mode_bl_d  = addr[2:0];
                        mode_bt_d  = addr[3];
                        mode_cl_d  = addr[6:4];
                        mode_wb_d  = addr[9];
                        init_ok_d  = 1'b1;
                        mrd_pend_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                // Only the first command after LOAD_MODE is checked.
                if (is_cmd && mrd_pend_q) begin
                    mrd_pend_d = 1'b0;
                    if (gap_q < GAP_MRD) begin
                        code      = 3'd6;
                        init_ok_d = 1'b0;
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = ERR;
            end
        endcase

        if (code != 3'd0) begin
            state_d    = ERR;
            init_err_d = 1'b1;
            err_code_d = code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_PWR;
            gap_q      <= '0;
            init_ok_q  <= 1'b0;
            init_err_q <= 1'b0;
            err_code_q <= '0;
            aref_cnt_q <= '0;
            mode_bl_q  <= '0;
            mode_bt_q  <= 1'b0;
            mode_cl_q  <= '0;
            mode_wb_q  <= 1'b0;
            mrd_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            init_ok_q  <= init_ok_d;
            init_err_q <= init_err_d;
            err_code_q <= err_code_d;
            aref_cnt_q <= aref_cnt_d;
            mode_bl_q  <= mode_bl_d;
            mode_bt_q  <= mode_bt_d;
            mode_cl_q  <= mode_cl_d;
            mode_wb_q  <= mode_wb_d;
            mrd_pend_q <= mrd_pend_d;
        end
    end

    assign init_ok  = init_ok_q;
    assign init_err = init_err_q;
    assign err_code = err_code_q;
    assign aref_cnt = aref_cnt_q;
    assign mode_bl  = mode_bl_q;
    assign mode_bt  = mode_bt_q;
    assign mode_cl  = mode_cl_q;
    assign mode_wb  = mode_wb_q;

endmodule

// File: tb/tb_sdram_init_checker.sv
// tb_sdram_init_checker: directed bench for sdram_init_checker.
// Drives on negedge, checks registered outputs on later negedges.
module tb_sdram_init_checker;

    localparam int TP = 100;

    localparam logic [3:0]  NOP  = 4'b0111;
    localparam logic [3:0]  PRE  = 4'b0010;
    localparam logic [3:0]  AREF = 4'b0001;
    localparam logic [3:0]  LMR  = 4'b0000;
    localparam logic [12:0] A10  = 13'h400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cmd;
    logic [1:0]  bank_addr;
    logic [12:0] addr;
    logic        init_ok;
    logic        init_err;
    logic [2:0]  err_code;
    logic [3:0]  aref_cnt;
    logic [2:0]  mode_bl;
    logic        mode_bt;
    logic [2:0]  mode_cl;
    logic        mode_wb;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sdram_init_checker #(
        .T_POWER(TP)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd),
        .bank_addr(bank_addr),
        .addr     (addr),
        .init_ok  (init_ok),
        .init_err (init_err),
        .err_code (err_code),
        .aref_cnt (aref_cnt),
        .mode_bl  (mode_bl),
        .mode_bt  (mode_bt),
        .mode_cl  (mode_cl),
        .mode_wb  (mode_wb)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] c, input logic [12:0] a);
        @(negedge clk);
        cmd       = c;
        addr      = a;
        bank_addr = 2'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(NOP, 13'd0);
    endtask

    // Release lands on a negedge with NOP; the next posedge is edge 0.
    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        cmd   = NOP;
        addr  = 13'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic to_pre();
        idle(TP - 1);
        step(PRE, A10);
    endtask

    task automatic aref2();
        to_pre();
        idle(1);
        step(AREF, 13'd0);
        idle(6);
        step(AREF, 13'd0);
    endtask

    task automatic nominal();
        aref2();
        idle(6);
        step(LMR, 13'h032);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd       = NOP;
        addr      = 13'd0;
        bank_addr = 2'd0;
        #12;
        check("rst_ok", int'(init_ok), 0);
        check("rst_err", int'(init_err), 0);
        check("rst_code", int'(err_code), 0);
        check("rst_aref", int'(aref_cnt), 0);
        check("rst_cl", int'(mode_cl), 0);

        // Nominal sequence
        reset_dut();
        nominal();
        idle(3);
        check("nom_ok", int'(init_ok), 1);
        check("nom_cl", int'(mode_cl), 3);
        check("nom_bl", int'(mode_bl), 2);
        check("nom_bt", int'(mode_bt), 0);
        check("nom_wb", int'(mode_wb), 0);
        check("nom_aref", int'(aref_cnt), 2);
        check("nom_err", int'(init_err), 0);
        check("nom_code", int'(err_code), 0);
        step(PRE, A10);
        idle(1);
        check("nom_post_ok", int'(init_ok), 1);

        // tMRD exact boundary, then unchecked commands
        reset_dut();
        nominal();
        idle(2);
        step(PRE, A10);
        idle(1);
        check("mrd3_ok", int'(init_ok), 1);
        check("mrd3_err", int'(init_err), 0);
        step(AREF, 13'd0);
        idle(1);
        check("done_free", int'(init_err), 0);

        // tMRD violation
        reset_dut();
        nominal();
        idle(1);
        step(PRE, A10);
        idle(1);
        check("mrd2_code", int'(err_code), 6);
        check("mrd2_ok", int'(init_ok), 0);
        check("mrd2_err", int'(init_err), 1);

        // PRECHARGE at edge 99, then a correct tail
        reset_dut();
        idle(TP - 2);
        step(PRE, A10);
        idle(1);
        check("pwr_code", int'(err_code), 1);
        check("pwr_err", int'(init_err), 1);
        step(AREF, 13'd0);
        idle(6);
        step(AREF, 13'd0);
        idle(6);
        step(LMR, 13'h032);
        idle(3);
        check("pwr_hold", int'(err_code), 1);
        check("pwr_nook", int'(init_ok), 0);

        // tRP violation
        reset_dut();
        to_pre();
        step(AREF, 13'd0);
        idle(1);
        check("trp1_code", int'(err_code), 3);

        // tRP exact, then LOAD_MODE after one AREF
        reset_dut();
        to_pre();
        idle(1);
        step(AREF, 13'd0);
        idle(1);
        check("trp2_err", int'(init_err), 0);
        check("trp2_aref", int'(aref_cnt), 1);
        idle(6);
        step(LMR, 13'h032);
        idle(1);
        check("aref1_code", int'(err_code), 5);
        check("aref1_ok", int'(init_ok), 0);

        // Illegal CAS latency
        reset_dut();
        aref2();
        idle(6);
        step(LMR, 13'h014);
        idle(1);
        check("cl1_code", int'(err_code), 7);
        check("cl1_cl", int'(mode_cl), 0);
        check("cl1_ok", int'(init_ok), 0);

        // tRFC violation
        reset_dut();
        to_pre();
        idle(1);
        step(AREF, 13'd0);
        idle(5);
        step(AREF, 13'd0);
        idle(1);
        check("trfc_code", int'(err_code), 4);
        check("trfc_aref", int'(aref_cnt), 1);

        // PRECHARGE without A10
        reset_dut();
        idle(TP - 1);
        step(PRE, 13'd0);
        idle(1);
        check("pre_a10", int'(err_code), 2);

        // Early LOAD_MODE reports the power-up code
        reset_dut();
        idle(49);
        step(LMR, 13'h032);
        idle(1);
        check("early_lmr", int'(err_code), 1);

        // Async reset mid-sequence
        reset_dut();
        aref2();
        idle(1);
        check("mid_aref", int'(aref_cnt), 2);
        #1 rst_n = 1'b0;
        #1;
        check("async_aref", int'(aref_cnt), 0);
        check("async_ok", int'(init_ok), 0);
        check("async_err", int'(init_err), 0);
        check("async_code", int'(err_code), 0);
        reset_dut();
        nominal();
        idle(1);
        check("rerun_ok", int'(init_ok), 1);
        check("rerun_aref", int'(aref_cnt), 2);
        check("rerun_err", int'(init_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
